// File: rtl/ascon_perm_iter_pkg.sv
// Shared types, constants and helpers for the iterative Ascon permutation.
package ascon_perm_iter_pkg;

    localparam int NB_ROUNDS_A_DEF = 12;
    localparam int NB_ROUNDS_B_DEF = 6;
    localparam logic [3:0] LAST_ROUND = 4'd11;

    // Five 64-bit words x0..x4; element 0 is x0.
    typedef logic [0:4][63:0] type_state;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } type_fsm;

    function automatic logic [7:0] round_const(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd0:    c = 8'hf0;
            4'd1:    c = 8'he1;
            4'd2:    c = 8'hd2;
            4'd3:    c = 8'hc3;
            4'd4:    c = 8'hb4;
            4'd5:    c = 8'ha5;
            4'd6:    c = 8'h96;
            4'd7:    c = 8'h87;
            4'd8:    c = 8'h78;
            4'd9:    c = 8'h69;
            4'd10:   c = 8'h5a;
            4'd11:   c = 8'h4b;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (32'd64 - n));
    endfunction

endpackage

// File: rtl/ascon_perm_iter_if.sv
// Request/response bundle between the mode FSM and the permutation engine.
interface ascon_perm_iter_if;
    import ascon_perm_iter_pkg::*;

    logic       start_i;
    logic       mode_b_i;
    type_state  state_i;
    type_state  state_o;
    logic [3:0] round_o;
    logic       busy_o;
    logic       done_o;

    modport master (output start_i, mode_b_i, state_i,
                    input  state_o, round_o, busy_o, done_o);
    modport slave  (input  start_i, mode_b_i, state_i,
                    output state_o, round_o, busy_o, done_o);
endinterface

// File: rtl/ascon_pc.sv
// Constant addition layer: XOR the round constant into x2.
module ascon_pc
    import ascon_perm_iter_pkg::*;
(
    input  type_state  src,
    input  logic [3:0] round,
    output type_state  res
);
    // Only the low byte of x2 receives the constant.
    always_comb begin
        res = src;
        res[2][7:0] = src[2][7:0] ^ round_const(round);
    end
endmodule

// File: rtl/ascon_pl.sv
// Linear diffusion layer: per-word XOR of two rotations.
module ascon_pl
    import ascon_perm_iter_pkg::*;
(
    input  type_state src,
    output type_state res
);
    assign res[0] = src[0] ^ rotr(src[0], 19) ^ rotr(src[0], 28);
    assign res[1] = src[1] ^ rotr(src[1], 61) ^ rotr(src[1], 39);
    assign res[2] = src[2] ^ rotr(src[2], 1)  ^ rotr(src[2], 6);
    assign res[3] = src[3] ^ rotr(src[3], 10) ^ rotr(src[3], 17);
    assign res[4] = src[4] ^ rotr(src[4], 7)  ^ rotr(src[4], 41);
endmodule

// File: rtl/ascon_ps.sv
// Substitution layer: bitsliced 5-bit Ascon S-box across all 64 columns.
module ascon_ps
    import ascon_perm_iter_pkg::*;
(
    input  type_state src,
    output type_state res
);
    logic [63:0] a0_s, a1_s, a2_s, a3_s, a4_s;
    logic [63:0] b0_s, b1_s, b2_s, b3_s, b4_s;

    assign a0_s = src[0] ^ src[4];
    assign a1_s = src[1];
    assign a2_s = src[2] ^ src[1];
    assign a3_s = src[3];
    assign a4_s = src[4] ^ src[3];

    assign b0_s = a0_s ^ (~a1_s & a2_s);
    assign b1_s = a1_s ^ (~a2_s & a3_s);
    assign b2_s = a2_s ^ (~a3_s & a4_s);
    assign b3_s = a3_s ^ (~a4_s & a0_s);
    assign b4_s = a4_s ^ (~a0_s & a1_s);

    assign res[0] = b0_s ^ b4_s;
    assign res[1] = b1_s ^ b0_s;
    assign res[2] = ~b2_s;
    assign res[3] = b3_s ^ b2_s;
    assign res[4] = b4_s;
endmodule

// File: rtl/ascon_round_cnt.sv
// Round index counter: reloadable, advances while enabled, saturates at the last round.
module ascon_round_cnt
    import ascon_perm_iter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic [3:0] cnt,
    output logic       last
);
    logic [3:0] cnt_r;

    // Counter register; reset outranks load, load outranks stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != LAST_ROUND)) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign last = (cnt_r == LAST_ROUND);
endmodule

// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation: one Pc->Ps->Pl round per clock over a registered 320-bit state.
module ascon_perm_iter
    import ascon_perm_iter_pkg::*;
#(
    parameter int NB_ROUNDS_A = NB_ROUNDS_A_DEF,
    parameter int NB_ROUNDS_B = NB_ROUNDS_B_DEF
) (
    input  logic               clock_i,
    input  logic               reset_i,
    ascon_perm_iter_if.slave   bus
);
    // Both variants end on round 11, so the start index is the round-count complement.
    localparam logic [3:0] START_A = 4'(12 - NB_ROUNDS_A);
    localparam logic [3:0] START_B = 4'(12 - NB_ROUNDS_B);

    type_fsm    fsm_r, fsm_s;
    type_state  state_r, pc_state_s, ps_state_s, pl_state_s;
    logic       load_s, run_s, last_s;
    logic [3:0] round_s, load_round_s;

    assign run_s        = (fsm_r == ST_RUN);
    assign load_round_s = bus.mode_b_i ? START_B : START_A;

    ascon_round_cnt u_cnt (
        .clk      (clock_i),
        .rst      (reset_i),
        .load     (load_s),
        .load_val (load_round_s),
        .en       (run_s),
        .cnt      (round_s),
        .last     (last_s)
    );

    ascon_pc u_pc (.src(state_r),    .round(round_s), .res(pc_state_s));
    ascon_ps u_ps (.src(pc_state_s), .res(ps_state_s));
    ascon_pl u_pl (.src(ps_state_s), .res(pl_state_s));

    // Next-state decode; start is honoured only from IDLE or DONE.
    always_comb begin
        fsm_s  = fsm_r;
        load_s = 1'b0;
        case (fsm_r)
            ST_IDLE: begin
                if (bus.start_i) begin
                    fsm_s  = ST_RUN;
                    load_s = 1'b1;
                end else begin
                    fsm_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) fsm_s = ST_DONE;
                else        fsm_s = ST_RUN;
            end
            ST_DONE: begin
                if (bus.start_i) begin
                    fsm_s  = ST_RUN;
                    load_s = 1'b1;
                end else begin
                    fsm_s = ST_IDLE;
                end
            end
            default: begin
                fsm_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock_i) begin
        if (reset_i) fsm_r <= ST_IDLE;
        else         fsm_r <= fsm_s;
    end

    // Permutation state: load on accepted start, one round per RUN cycle, hold otherwise.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_r <= '0;
        end else if (load_s) begin
            state_r <= bus.state_i;
        end else if (run_s) begin
            state_r <= pl_state_s;
        end else begin
            state_r <= state_r;
        end
    end

    assign bus.state_o = state_r;
    assign bus.round_o = round_s;
    assign bus.busy_o  = (fsm_r == ST_RUN);
    assign bus.done_o  = (fsm_r == ST_DONE);
endmodule
